// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core MEM
// stage (port 0) and the IO bus engine (port 1), with one-cycle read return routing.
module data_memory_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [XLEN-1:0]       core_wdata,
    output logic                  core_gnt,
    output logic                  core_stall,
    output logic                  core_rvalid,
    output logic [XLEN-1:0]       core_rdata,

    input  logic                  io_req,
    input  logic                  io_we,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    input  logic [XLEN-1:0]       io_wdata,
    output logic                  io_gnt,
    output logic                  io_rvalid,
    output logic [XLEN-1:0]       io_rdata,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [XLEN-1:0]       mem_data,
    output logic                  mem_wren,
    input  logic [XLEN-1:0]       mem_q
);

    // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt in
    // the same cycle; the access is taken on that cycle's rising edge, and a read
    // returns exactly one rvalid on the following cycle.

    logic last_gnt;  // 0 = core won last, 1 = io won last
    logic rd_pend;
    logic rd_owner;  // 0 = core, 1 = io

    always_comb begin
        core_gnt    = 1'b0;
        io_gnt      = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (!reset) begin
            // On a tie the port that did not win most recently is served.
            if (core_req && (!io_req || last_gnt)) begin
                core_gnt = 1'b1;
            end else if (io_req) begin
                io_gnt = 1'b1;
            end
        end
        if (core_gnt) begin
            mem_address = core_addr;
            mem_data    = core_wdata;
            mem_wren    = core_we;
        end else if (io_gnt) begin
            mem_address = io_addr;
            mem_data    = io_wdata;
            mem_wren    = io_we;
        end
    end

    assign core_stall = core_req && !core_gnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (core_gnt || io_gnt) begin
                last_gnt <= io_gnt;
            end
            rd_pend  <= (core_gnt && !core_we) || (io_gnt && !io_we);
            rd_owner <= io_gnt;
        end
    end

    assign core_rvalid = rd_pend && !rd_owner;
    assign io_rvalid   = rd_pend && rd_owner;
    assign core_rdata  = core_rvalid ? mem_q : '0;
    assign io_rdata    = io_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: driver checks grants in-cycle, a
// negedge monitor pops expected read returns from a scoreboard queue.
module tb_data_memory_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0]   core_addr = '0;
    logic [XLEN-1:0] core_wdata = '0;
    logic            io_req = 1'b0, io_we = 1'b0;
    logic [AW-1:0]   io_addr = '0;
    logic [XLEN-1:0] io_wdata = '0;
    logic            core_gnt, core_stall, core_rvalid;
    logic [XLEN-1:0] core_rdata;
    logic            io_gnt, io_rvalid;
    logic [XLEN-1:0] io_rdata;
    logic [AW-1:0]   mem_address;
    logic [XLEN-1:0] mem_data;
    logic            mem_wren;
    logic [XLEN-1:0] mem_q;

    int checks = 0;
    int errors = 0;
    logic [XLEN:0] exp_q[$];  // {port, data}

    data_memory_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
        .clock(clk), .reset(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_gnt(io_gnt),
        .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Preload value for every address; 0x010 carries the named test word.
    function automatic logic [XLEN-1:0] init_word(input int a);
        if (a == 'h010) return 32'hDEAD_BEEF;
        return 32'hA000_0000 | a;
    endfunction

    // Registered single-port memory model.
    logic [XLEN-1:0] mem [512];
    logic            mem_loaded = 1'b0;
    logic [XLEN-1:0] mem_q_r = '0;
    assign mem_q = mem_q_r;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_wren) begin
            mem[mem_address] <= mem_data;
        end
        mem_q_r <= mem[mem_address];
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [XLEN:0] act, input logic [XLEN:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                         input logic [XLEN-1:0] cwd, input logic ireq, input logic iwe,
                         input logic [AW-1:0] iaddr, input logic [XLEN-1:0] iwd);
        @(posedge clk);
        #1;
        core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        io_req = ireq; io_we = iwe; io_addr = iaddr; io_wdata = iwd;
        #3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic push_exp(input logic port, input logic [XLEN-1:0] data);
        exp_q.push_back({port, data});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            idle();
            n++;
        end
        idle();
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        core_req = 1'b0; io_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [XLEN:0] e;
        if (core_rvalid && io_rvalid) begin
            check("both_rvalid", 1, 0);
        end else if (core_rvalid || io_rvalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {io_rvalid, (io_rvalid ? io_rdata : core_rdata)}, 0);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_port", io_rvalid, e[XLEN]);
                check("rdata", io_rvalid ? io_rdata : core_rdata, e[XLEN-1:0]);
            end
        end
        if (!core_rvalid) check("core_rdata_zero", core_rdata, 0);
        if (!io_rvalid)   check("io_rdata_zero", io_rdata, 0);
    end

    // ---------------- stimulus ----------------
    initial begin
        int ci, ii;

        // Reset: grants suppressed, stall follows req.
        @(posedge clk);
        #1;
        core_req = 1'b1;
        #3;
        check("rst_core_gnt", core_gnt, 0);
        check("rst_io_gnt", io_gnt, 0);
        check("rst_core_stall", core_stall, 1);
        check("rst_mem_wren", mem_wren, 0);
        check("rst_core_rvalid", core_rvalid, 0);
        core_req = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Core only read of 0x010.
        drive(1'b1, 1'b0, 9'h010, '0, 1'b0, 1'b0, '0, '0);
        check("c1_core_gnt", core_gnt, 1);
        check("c1_core_stall", core_stall, 0);
        check("c1_io_gnt", io_gnt, 0);
        check("c1_mem_address", mem_address, 9'h010);
        check("c1_mem_wren", mem_wren, 0);
        push_exp(1'b0, 32'hDEAD_BEEF);
        drain();

        // Conflict after reset: core, io, core.
        pulse_reset();
        drive(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h040, '0);
        check("t2_c0_core_gnt", core_gnt, 1);
        check("t2_c0_io_gnt", io_gnt, 0);
        check("t2_c0_core_stall", core_stall, 0);
        push_exp(1'b0, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 9'h041, '0, 1'b1, 1'b0, 9'h040, '0);
        check("t2_c1_io_gnt", io_gnt, 1);
        check("t2_c1_core_stall", core_stall, 1);
        check("t2_c1_mem_address", mem_address, 9'h040);
        push_exp(1'b1, 32'hA000_0040);
        drive(1'b1, 1'b0, 9'h041, '0, 1'b0, 1'b0, '0, '0);
        check("t2_c2_core_gnt", core_gnt, 1);
        push_exp(1'b0, 32'hA000_0041);
        drain();

        // Sustained contention: strict alternation starting with core.
        pulse_reset();
        ci = 0;
        ii = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 9'(9'h040 + ci), '0, 1'b1, 1'b0, 9'(9'h048 + ii), '0);
            if (i % 2 == 0) begin
                check("t3_core_gnt", core_gnt, 1);
                check("t3_io_gnt", io_gnt, 0);
                push_exp(1'b0, 32'hA000_0040 + ci);
                ci++;
            end else begin
                check("t3_io_gnt", io_gnt, 1);
                check("t3_core_stall", core_stall, 1);
                push_exp(1'b1, 32'hA000_0048 + ii);
                ii++;
            end
        end
        drain();

        // IO write then core read of the same word.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 9'h020, 32'h1234_5678);
        check("t4_io_gnt", io_gnt, 1);
        check("t4_mem_wren", mem_wren, 1);
        check("t4_mem_address", mem_address, 9'h020);
        check("t4_mem_data", mem_data, 32'h1234_5678);
        drive(1'b1, 1'b0, 9'h020, '0, 1'b0, 1'b0, '0, '0);
        check("t4_core_gnt", core_gnt, 1);
        check("t4_rd_mem_wren", mem_wren, 0);
        push_exp(1'b0, 32'h1234_5678);
        drain();

        // Reset mid-read: granted read must never return.
        drive(1'b1, 1'b0, 9'h010, '0, 1'b0, 1'b0, '0, '0);
        check("t5_core_gnt", core_gnt, 1);
        rst = 1'b1;
        #0;
        check("t5_rst_core_gnt", core_gnt, 0);
        check("t5_rst_core_stall", core_stall, 1);
        check("t5_rst_mem_wren", mem_wren, 0);
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 9'h011, '0, 1'b1, 1'b0, 9'h012, '0);
        check("t5_tie_core_gnt", core_gnt, 1);
        check("t5_tie_io_gnt", io_gnt, 0);
        push_exp(1'b0, 32'hA000_0011);

        // Idle for 5 cycles, then a tie must go to io (core won last).
        for (int i = 0; i < 5; i++) begin
            idle();
            check("t6_core_gnt", core_gnt, 0);
            check("t6_io_gnt", io_gnt, 0);
            check("t6_mem_wren", mem_wren, 0);
            if (i > 0) check("t6_rvalid", {core_rvalid, io_rvalid}, 0);
        end
        check("t6_queue_empty", exp_q.size(), 0);
        drive(1'b1, 1'b0, 9'h013, '0, 1'b1, 1'b0, 9'h014, '0);
        check("t6_tie_io_gnt", io_gnt, 1);
        check("t6_tie_core_stall", core_stall, 1);
        push_exp(1'b1, 32'hA000_0014);
        drive(1'b1, 1'b0, 9'h013, '0, 1'b0, 1'b0, '0, '0);
        check("t6_core_gnt_after", core_gnt, 1);
        push_exp(1'b0, 32'hA000_0013);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
